imem_rsp: RTL and testbench

Instruction-memory responder: the memory side of the core's fetch interface. Accepts a fetch address over a valid/ready request channel and returns the 32-bit instruction word over a valid/ready response channel after a programmable latency. Backed by an internal word-addressed array mapped at the reset PC (0x80000000). A side-band load port fills the array before or during simulation.

---
 rtl/imem_rsp.sv | 195 +++++++++++++++++++
 tb/tb_imem_rsp.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_rsp.sv
// ============================================================================
// imem_rsp
// ----------------------------------------------------------------------------
// Instruction-memory responder. This is the memory side of the core's fetch
// interface. It accepts one fetch address at a time on a valid/ready request
// channel. After a programmable number of wait cycles it returns the 32-bit
// instruction word on a valid/ready response channel.
//
// The backing store is an internal word-addressed array. Word 0 sits at byte
// address BASE_ADDR, which defaults to the reset PC 0x80000000. A side-band
// load port writes the array in any state, including while reset is held.
// The array is never cleared, so program images survive a core reset.
//
// Parameters
//   BASE_ADDR   byte address of word 0
//   DEPTH_LOG2  array holds 2**DEPTH_LOG2 32-bit words
//   LATENCY     wait cycles between acceptance and response (0..15)
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   req_valid_i  fetch request valid
//   req_ready_o  responder can accept a request (registered)
//   req_addr_i   fetch byte address (PC)
//   rsp_valid_o  response valid (registered)
//   rsp_ready_i  core accepts the response
//   rsp_instr_o  instruction word (registered)
//   rsp_err_o    access fault, qualified by rsp_valid_o (registered)
//   ld_en_i      array write enable
//   ld_addr_i    word index to write
//   ld_data_i    word to write
//
// Build option
//   IMEM_FAULT_CHECK_EN  When this macro is defined, a request is faulted if
//                        its address is misaligned or lies outside the
//                        array. A faulted request still takes the normal
//                        latency. It answers with rsp_err_o=1 and an ebreak
//                        word, so the core halts. When the macro is not
//                        defined, address bits [1:0] are ignored, the index
//                        wraps modulo the array depth, and rsp_err_o is
//                        always 0.
// ============================================================================
module imem_rsp #(
    parameter logic [31:0] BASE_ADDR  = 32'h80000000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [31:0]           req_addr_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_instr_o,
    output logic                  rsp_err_o,
    input  logic                  ld_en_i,
    input  logic [DEPTH_LOG2-1:0] ld_addr_i,
    input  logic [31:0]           ld_data_i
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // The countdown counter starts at LATENCY-1. With LATENCY=0 the WAIT
    // state is skipped entirely, so the load value does not matter there.
    localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic                  ready_q;
    logic                  valid_q;
    logic [31:0]           instr_q;
    logic                  err_q;

    logic [31:0]           mem [DEPTH];

    logic [31:0]           offset;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [31:0]           rd_word;
    logic                  accept;
    logic [31:0]           nxt_instr;
    logic                  nxt_err;

    // The offset is a plain 32-bit unsigned subtract. An address below
    // BASE_ADDR wraps to a huge offset, which the fault check treats as out
    // of range. Without the fault check, only the index bits are kept.
    assign offset  = req_addr_i - BASE_ADDR;
    assign rd_idx  = offset[DEPTH_LOG2+1:2];
    assign rd_word = mem[rd_idx];

    // ready_q is high only in IDLE. It is held low for the first cycle after
    // reset, so acceptance needs no separate state decode.
    assign accept = req_valid_i && ready_q;

`ifdef IMEM_FAULT_CHECK_EN
    localparam logic [31:0] EBREAK = 32'h00100073;

    logic fault;
    logic [1:0] unused_offset_lsb;

    // Any offset bit above the index field means the word lies beyond the
    // array. This covers wrapped (negative) offsets as well.
    assign fault = (req_addr_i[1:0] != 2'b00) ||
                   (offset[31:DEPTH_LOG2+2] != '0);
    assign unused_offset_lsb = offset[1:0];

    assign nxt_instr = fault ? EBREAK : rd_word;
    assign nxt_err   = fault;
`else
    logic unused_addr_bits;

    // The high offset bits and the byte-lane bits play no part when the
    // index simply wraps.
    assign unused_addr_bits = ^{offset[31:DEPTH_LOG2+2], offset[1:0]};

    assign nxt_instr = rd_word;
    assign nxt_err   = 1'b0;
`endif

    // Array write port. It has no reset, so contents persist across rst_i.
    // A read in the same cycle as a write to the same word sees the old
    // value, because the response register samples mem before this edge
    // commits the write.
    always_ff @(posedge clk_i) begin
        if (ld_en_i) begin
            mem[ld_addr_i] <= ld_data_i;
        end
    end

    // Request/response sequencer. All outputs are registered here, so no
    // input reaches an output combinationally. Array data is captured only
    // at acceptance. A pending response therefore ignores later loads, and
    // a reset in WAIT or RESP drops the response without presenting it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        instr_q <= nxt_instr;
                        err_q   <= nxt_err;
                        cnt_q   <= CNT_LOAD;
                        ready_q <= 1'b0;
                        if (LATENCY > 0) begin
                            state_q <= WAIT;
                        end else begin
                            state_q <= RESP;
                            valid_q <= 1'b1;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                        valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = valid_q;
    assign rsp_instr_o = instr_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_imem_rsp.sv
// ============================================================================
// tb_imem_rsp
// ----------------------------------------------------------------------------
// Bench for imem_rsp. It runs two instances side by side, one with
// LATENCY=2 and one with LATENCY=0, each with 64 words. Both instances share
// clock, reset and the load port. Each has its own request/response signals.
//
// The reference model works at transaction level. A request accepted at
// edge A is due from edge A+LATENCY until a response handshake. Its data
// comes from an array model read before that edge's load is applied.
// Inputs are snapshotted on the rising edge. The model and the compare step
// run on the falling edge. Directed tests pin the model with literal
// expected values. Randomised traffic then exercises everything together.
// ============================================================================
`timescale 1ns/1ps
module tb_imem_rsp;

    localparam logic [31:0] BASE   = 32'h80000000;
    localparam int          DL2    = 6;
    localparam int          DEPTH  = 1 << DL2;
    localparam logic [31:0] EBREAK = 32'h00100073;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           req_valid [2];
    logic [31:0]    req_addr  [2];
    logic           rsp_ready [2];
    logic           rdy_o     [2];
    logic           vld_o     [2];
    logic [31:0]    instr_o   [2];
    logic           err_o     [2];
    logic           ld_en;
    logic [DL2-1:0] ld_addr;
    logic [31:0]    ld_data;

    int checks = 0;
    int errors = 0;
    int tb_cyc = 0;

    imem_rsp #(.BASE_ADDR(BASE), .DEPTH_LOG2(DL2), .LATENCY(2)) u_lat2 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid[0]), .req_ready_o(rdy_o[0]), .req_addr_i(req_addr[0]),
        .rsp_valid_o(vld_o[0]), .rsp_ready_i(rsp_ready[0]),
        .rsp_instr_o(instr_o[0]), .rsp_err_o(err_o[0]),
        .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
    );

    imem_rsp #(.BASE_ADDR(BASE), .DEPTH_LOG2(DL2), .LATENCY(0)) u_lat0 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid[1]), .req_ready_o(rdy_o[1]), .req_addr_i(req_addr[1]),
        .rsp_valid_o(vld_o[1]), .rsp_ready_i(rsp_ready[1]),
        .rsp_instr_o(instr_o[1]), .rsp_err_o(err_o[1]),
        .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference rules: fault classification and word index for an address
    function automatic logic modelFault(input logic [31:0] addr);
`ifdef IMEM_FAULT_CHECK_EN
        logic [31:0] off;
        off = addr - BASE;
        return (addr % 4 != 0) || (off >= 4 * DEPTH);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int modelIndex(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return int'((off / 4) % DEPTH);
    endfunction

    // Input snapshot at the rising edge
    logic           s_rst;
    logic           s_rv [2];
    logic           s_rr [2];
    logic [31:0]    s_addr [2];
    logic           s_ld;
    logic [DL2-1:0] s_lda;
    logic [31:0]    s_ldd;

    always @(posedge clk) begin
        tb_cyc    <= tb_cyc + 1;
        s_rst     <= rst;
        s_rv[0]   <= req_valid[0];
        s_rv[1]   <= req_valid[1];
        s_rr[0]   <= rsp_ready[0];
        s_rr[1]   <= rsp_ready[1];
        s_addr[0] <= req_addr[0];
        s_addr[1] <= req_addr[1];
        s_ld      <= ld_en;
        s_lda     <= ld_addr;
        s_ldd     <= ld_data;
    end

    // Transaction-level model plus the per-cycle compare
    logic [31:0] mem_m [DEPTH];
    bit          live = 0;
    int          edge_n = 0;
    bit          busy  [2];
    int          acc   [2];
    bit          e_rdy [2];
    bit          e_vld [2];
    logic [31:0] e_instr [2];
    logic        e_err [2];
    int          lat_of [2];

    initial begin
        lat_of[0] = 2;
        lat_of[1] = 0;
        for (int k = 0; k < 2; k++) begin
            busy[k] = 0; acc[k] = 0; e_rdy[k] = 0; e_vld[k] = 0;
            e_instr[k] = '0; e_err[k] = 1'b0;
        end
    end

    always @(negedge clk) begin
        edge_n++;
        if (s_rst === 1'b1) live = 1;
        for (int k = 0; k < 2; k++) begin
            if (s_rst === 1'b1) begin
                busy[k] = 0;
                e_instr[k] = '0;
                e_err[k] = 1'b0;
            end else if (e_vld[k] && s_rr[k] === 1'b1) begin
                busy[k] = 0;
            end else if (e_rdy[k] && s_rv[k] === 1'b1) begin
                busy[k] = 1;
                acc[k] = edge_n;
                if (modelFault(s_addr[k])) begin
                    e_instr[k] = EBREAK;
                    e_err[k] = 1'b1;
                end else begin
                    e_instr[k] = mem_m[modelIndex(s_addr[k])];
                    e_err[k] = 1'b0;
                end
            end
            e_rdy[k] = !busy[k] && (s_rst !== 1'b1);
            e_vld[k] = busy[k] && (edge_n >= acc[k] + lat_of[k]);
        end
        if (s_ld === 1'b1) mem_m[s_lda] = s_ldd;
        if (live) begin
            for (int k = 0; k < 2; k++) begin
                checkOutput($sformatf("u%0d_ready", k), rdy_o[k], e_rdy[k]);
                checkOutput($sformatf("u%0d_valid", k), vld_o[k], e_vld[k]);
                if (e_vld[k] || s_rst === 1'b1) begin
                    checkOutput($sformatf("u%0d_instr", k), instr_o[k], e_instr[k]);
                    checkOutput($sformatf("u%0d_err", k), err_o[k], e_err[k]);
                end
            end
        end
    end

    // One fetch on instance k. Waits for ready, optionally loads a word in
    // the acceptance cycle, then waits for the response.
    task automatic doReq(input int k, input logic [31:0] addr, input logic rr,
                         input bit ld_now, input logic [DL2-1:0] lidx, input logic [31:0] lword,
                         output logic [31:0] w, output logic e, output int lat, output int acyc);
        int n;
        @(negedge clk);
        req_valid[k] = 1'b1;
        req_addr[k]  = addr;
        rsp_ready[k] = rr;
        n = 0;
        while (rdy_o[k] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("req_ready_timeout", rdy_o[k], 1);
        if (ld_now) begin
            ld_en = 1'b1; ld_addr = lidx; ld_data = lword;
        end
        acyc = tb_cyc;
        @(negedge clk);
        req_valid[k] = 1'b0;
        ld_en = 1'b0;
        lat = 1;
        while (vld_o[k] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("rsp_valid_timeout", vld_o[k], 1);
        w = instr_o[k];
        e = err_o[k];
    endtask

    function automatic logic [31:0] randAddr();
        case ($urandom_range(0, 9))
            0:       return BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
            1:       return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, DEPTH - 1));
            2:       return BASE - 32'(4 * $urandom_range(1, 8));
            3:       return $urandom;
            default: return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        endcase
    endfunction

    // One cycle of randomised traffic. A pending request is held until
    // it is accepted, as the requester protocol requires.
    task automatic applyStimulus();
        rst = ($urandom_range(0, 299) == 0);
        for (int k = 0; k < 2; k++) begin
            if (!(req_valid[k] === 1'b1 && rdy_o[k] !== 1'b1)) begin
                req_valid[k] = ($urandom_range(0, 99) < 60);
                req_addr[k]  = randAddr();
            end
            rsp_ready[k] = ($urandom_range(0, 99) < 70);
        end
        ld_en   = ($urandom_range(0, 99) < 20);
        ld_addr = DL2'($urandom_range(0, DEPTH - 1));
        ld_data = $urandom;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] w;
        logic        e;
        int          lat;
        int          a1;
        int          a2;

        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0; req_addr[k] = BASE; rsp_ready[k] = 1'b1;
        end
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        rst = 1'b1;

        // Fill the array while reset is held; the load port works in reset
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            ld_en   = 1'b1;
            ld_addr = i[DL2-1:0];
            ld_data = (i == 0) ? 32'h00000413 :
                      (i == 1) ? 32'h00100073 :
                      (i == 3) ? 32'h11111111 : $urandom;
        end
        @(negedge clk);
        ld_en = 1'b0;
        checkOutput("reset_ready", rdy_o[0], 0);
        checkOutput("reset_valid", vld_o[0], 0);
        checkOutput("reset_instr", instr_o[0], 32'h0);
        checkOutput("reset_err", err_o[0], 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_ready", rdy_o[0], 1);

        // Basic fetches at LATENCY=2
        doReq(0, BASE, 1'b1, 0, '0, '0, w, e, lat, a1);
        checkOutput("fetch_word0", w, 32'h00000413);
        checkOutput("fetch_word0_err", e, 0);
        checkOutput("fetch_latency2", lat, 3);
        doReq(0, BASE + 32'd4, 1'b1, 0, '0, '0, w, e, lat, a2);
        checkOutput("fetch_word1", w, 32'h00100073);
        checkOutput("throughput_lat2", a2 - a1, 4);

        // Backpressure holds the response stable
        doReq(0, BASE + 32'd8, 1'b0, 0, '0, '0, w, e, lat, a1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_valid", vld_o[0], 1);
            checkOutput("bp_instr", instr_o[0], w);
            checkOutput("bp_err", err_o[0], e);
            checkOutput("bp_ready", rdy_o[0], 0);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_valid", vld_o[0], 0);
        checkOutput("bp_release_ready", rdy_o[0], 1);

        // LATENCY=0 instance
        doReq(1, BASE, 1'b1, 0, '0, '0, w, e, lat, a1);
        checkOutput("lat0_word0", w, 32'h00000413);
        checkOutput("lat0_latency", lat, 1);
        doReq(1, BASE + 32'd4, 1'b1, 0, '0, '0, w, e, lat, a2);
        checkOutput("lat0_word1", w, 32'h00100073);
        checkOutput("throughput_lat0", a2 - a1, 2);

        // Same-cycle load and acceptance: the old word is returned
        doReq(0, BASE + 32'hC, 1'b1, 1, DL2'(3), 32'hDEADBEEF, w, e, lat, a1);
        checkOutput("rbw_old_word", w, 32'h11111111);
        doReq(0, BASE + 32'hC, 1'b1, 0, '0, '0, w, e, lat, a1);
        checkOutput("rbw_new_word", w, 32'hDEADBEEF);

        // Reset while waiting drops the response; contents survive
        @(negedge clk);
        checkOutput("rw_ready_before", rdy_o[0], 1);
        req_valid[0] = 1'b1; req_addr[0] = BASE;
        @(negedge clk);
        req_valid[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rw_in_reset_ready", rdy_o[0], 0);
        @(negedge clk);
        checkOutput("rw_ready_after", rdy_o[0], 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("rw_no_response", vld_o[0], 0);
        end
        doReq(0, BASE, 1'b1, 0, '0, '0, w, e, lat, a1);
        checkOutput("rw_retained", w, 32'h00000413);

        // Misaligned and below-base addresses
`ifdef IMEM_FAULT_CHECK_EN
        doReq(0, BASE + 32'd2, 1'b1, 0, '0, '0, w, e, lat, a1);
        checkOutput("fault_unaligned_err", e, 1);
        checkOutput("fault_unaligned_instr", w, EBREAK);
        doReq(0, 32'h7FFFFFFC, 1'b1, 0, '0, '0, w, e, lat, a1);
        checkOutput("fault_below_err", e, 1);
        checkOutput("fault_below_instr", w, EBREAK);
`else
        doReq(0, BASE + 32'd2, 1'b1, 0, '0, '0, w, e, lat, a1);
        checkOutput("nofault_unaligned_instr", w, 32'h00000413);
        checkOutput("nofault_unaligned_err", e, 0);
`endif

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            applyStimulus();
        end
        @(negedge clk);
        rst = 1'b0; ld_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0; rsp_ready[k] = 1'b1;
        end
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
